// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline-stage register for the SPARC core. Carries an opaque
//   payload plus a write-enable bitmask under a valid/ready handshake. A
//   two-entry skid buffer (main + skid) sustains one transfer per cycle while
//   in_ready comes straight from a flop. Empty slots present NOP_VALUE with
//   all write enables cleared.
//
//   Optional statistics: define PIPE_STAGE_ELASTIC_STATS_EN to add the
//   stall_cnt and flush_drop_cnt outputs.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          synchronous active-high reset
//   flush          kill every held entry (and any same-cycle accept)
//   in_valid       upstream holds an instruction
//   in_ready       stage can accept (registered)
//   in_data        upstream payload            [DATA_W]
//   in_wen         upstream write enables      [WEN_W]
//   out_valid      stage holds an instruction
//   out_ready      downstream accepts (low = stall)
//   out_data       head payload or NOP_VALUE   [DATA_W]
//   out_wen        head write enables or 0     [WEN_W]
//   stall_cnt      (stats) cycles with out_valid & !out_ready, saturating
//   flush_drop_cnt (stats) entries killed by flush, saturating
module pipe_stage_elastic #(
  parameter int unsigned          DATA_W    = 128,
  parameter int unsigned          WEN_W     = 4,
  parameter logic [DATA_W-1:0]    NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WEN_W-1:0]  in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WEN_W-1:0]  out_wen
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   main_data, skid_data;
  logic [WEN_W-1:0]    main_wen,  skid_wen;
  logic                accept, issue;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign issue     = out_valid & out_ready;

  // Outputs are muxes of flops only; no in_* to out_* path.
  assign out_data  = out_valid ? main_data : NOP_VALUE;
  assign out_wen   = out_valid ? main_wen  : '0;

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (issue && !accept)      state_next = EMPTY;
        else if (!issue && accept) state_next = TWO;
      end
      TWO:     if (issue) state_next = ONE;
      default: state_next = EMPTY;
    endcase
    if (flush) state_next = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      // Registered: low only while two entries will be held.
      in_ready <= (state_next != TWO);
    end
  end

  // NOTE: the payload registers carry no reset; their contents are only
  // observed while state marks them valid, so resetting them buys nothing.
  // Writes during a flush are harmless because the state goes EMPTY.
  always_ff @(posedge clk) begin
    unique case (state)
      EMPTY: begin
        if (accept) begin
          main_data <= in_data;
          main_wen  <= in_wen;
        end
      end
      ONE: begin
        if (accept && issue) begin
          main_data <= in_data;
          main_wen  <= in_wen;
        end else if (accept) begin
          skid_data <= in_data;
          skid_wen  <= in_wen;
        end
      end
      TWO: begin
        if (issue) begin
          main_data <= skid_data;
          main_wen  <= skid_wen;
        end
      end
      default: ;
    endcase
  end

`ifdef PIPE_STAGE_ELASTIC_STATS_EN
  logic [1:0]  held_cnt;
  logic [1:0]  killed_cnt;
  logic [16:0] drop_sum;

  // An entry issued in the flush cycle was consumed downstream, so it is not
  // a drop; a same-cycle accept is.
  always_comb begin
    unique case (state)
      ONE:     held_cnt = 2'd1;
      TWO:     held_cnt = 2'd2;
      default: held_cnt = 2'd0;
    endcase
    killed_cnt = held_cnt + {1'b0, accept} - {1'b0, issue};
    drop_sum   = {1'b0, flush_drop_cnt} + {15'd0, killed_cnt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt      <= '0;
      flush_drop_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush)
        flush_drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic: directed stimulus with a scoreboard.
// The monitor pushes each accepted input into an expected queue and pops it
// when the DUT issues; flush and reset empty the queue. The stimulus process
// also checks hand-computed values at specific cycles.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 128;
  localparam int WEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [WEN_W-1:0]  in_wen, out_wen;
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_drop_cnt;
`endif

  pipe_stage_elastic #(.DATA_W(DATA_W), .WEN_W(WEN_W), .NOP_VALUE('0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_wen(out_wen)
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    , .stall_cnt(stall_cnt), .flush_drop_cnt(flush_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [WEN_W-1:0]  wen;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_issued = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle, when inputs and outputs are settled for the
  // coming posedge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_issued++;
        if (exp_q.size() == 0) begin
          check("unexpected_issue", out_data, '1);
        end else begin
          entry_t e;
          e = exp_q.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_wen", {{(DATA_W-WEN_W){1'b0}}, out_wen},
                {{(DATA_W-WEN_W){1'b0}}, e.wen});
        end
      end else if (!out_valid) begin
        check("nop_data", out_data, '0);
        check("nop_wen", {{(DATA_W-WEN_W){1'b0}}, out_wen}, '0);
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back('{data: in_data, wen: in_wen});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] w,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = {120'd0, d};
    in_wen    = w;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_wen", {124'd0, out_wen}, 0);
    check("rst_in_ready", {127'd0, in_ready}, 1);

    // Stream 0x10..0x17, each visible one cycle after its accept.
    for (int i = 0; i < 8; i++) begin
      cyc();
      drive(1'b1, 8'h10 + 8'(i), 4'b0101, 1'b1, 1'b0);
      @(negedge clk);
      check("stream_in_ready", {127'd0, in_ready}, 1);
      if (i > 0) begin
        check("stream_valid", {127'd0, out_valid}, 1);
        check("stream_data", out_data, 128'(8'h10 + 8'(i - 1)));
      end
    end
    cyc();
    drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("stream_last", out_data, 128'h17);
    cyc();
    @(negedge clk);
    check("stream_drained", {127'd0, out_valid}, 0);

    // Stall: A1 held, A2 to skid, A3 waits upstream.
    cyc(); drive(1'b1, 8'hA1, 4'b1010, 1'b1, 1'b0);
    cyc(); drive(1'b1, 8'hA2, 4'b1010, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_head_a1", out_data, 128'hA1);
    check("stall_rdy_one", {127'd0, in_ready}, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(); drive(1'b1, 8'hA3, 4'b1010, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_rdy_two", {127'd0, in_ready}, 0);
      check("stall_hold_a1", out_data, 128'hA1);
    end
    cyc(); drive(1'b1, 8'hA3, 4'b1010, 1'b1, 1'b0);
    @(negedge clk);
    check("release_a1", out_data, 128'hA1);
    cyc();
    @(negedge clk);
    check("release_a2", out_data, 128'hA2);
    check("release_rdy", {127'd0, in_ready}, 1);
    cyc(); drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("release_a3", out_data, 128'hA3);
    cyc();

    // Flush while TWO with B3 offered.
    cyc(); drive(1'b1, 8'hB1, 4'b0011, 1'b0, 1'b0);
    cyc(); drive(1'b1, 8'hB2, 4'b0011, 1'b0, 1'b0);
    cyc(); drive(1'b1, 8'hB3, 4'b0011, 1'b0, 1'b1);
    @(negedge clk);
    check("flush2_rdy_before", {127'd0, in_ready}, 0);
    cyc(); drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush2_valid", {127'd0, out_valid}, 0);
    check("flush2_wen", {124'd0, out_wen}, 0);
    check("flush2_rdy", {127'd0, in_ready}, 1);
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    check("flush2_drop_cnt", {112'd0, flush_drop_cnt}, 2);
`endif

    // Flush while ONE with an accepting input.
    cyc(); drive(1'b1, 8'hC1, 4'b1111, 1'b0, 1'b0);
    cyc(); drive(1'b1, 8'hC2, 4'b1111, 1'b0, 1'b1);
    @(negedge clk);
    check("flush1_rdy_before", {127'd0, in_ready}, 1);
    check("flush1_valid_before", {127'd0, out_valid}, 1);
    cyc(); drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush1_valid", {127'd0, out_valid}, 0);
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    check("flush1_drop_cnt", {112'd0, flush_drop_cnt}, 4);
`endif

    // Reset while TWO and stalled.
    cyc(); drive(1'b1, 8'hD1, 4'b0110, 1'b0, 1'b0);
    cyc(); drive(1'b1, 8'hD2, 4'b0110, 1'b0, 1'b0);
    cyc(); drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_two", {127'd0, in_ready}, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("rst2_valid", {127'd0, out_valid}, 0);
    check("rst2_rdy", {127'd0, in_ready}, 1);
    check("rst2_wen", {124'd0, out_wen}, 0);
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    check("rst2_stall_cnt", {96'd0, stall_cnt}, 0);
    check("rst2_drop_cnt", {112'd0, flush_drop_cnt}, 0);
`endif

    // Recovery after reset.
    cyc(); drive(1'b1, 8'hE0, 4'b1001, 1'b1, 1'b0);
    cyc(); drive(1'b1, 8'hE1, 4'b1001, 1'b1, 1'b0);
    @(negedge clk);
    check("recover_e0", out_data, 128'hE0);
    cyc(); drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("recover_e1", out_data, 128'hE1);
    cyc(); cyc(); cyc();
    @(negedge clk);

    // 8 stream + 3 stall + 2 recovery entries delivered; nothing outstanding.
    check("issued_total", 128'(n_issued), 128'd13);
    check("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
